// File: rtl/pixel_sink_pkg.sv
// Shared screen geometry, pixel field widths and sink FSM encodings for the pixel sink slice.
package pixel_sink_pkg;
    localparam int X_COORD_WIDTH = 8;
    localparam int Y_COORD_WIDTH = 7;
    localparam int COLOUR_WIDTH  = 3;
    localparam int SCREEN_WIDTH  = 160;
    localparam int SCREEN_HEIGHT = 120;

    typedef enum logic [1:0] {
        SINK_ACCEPT = 2'd0,
        SINK_DRAIN  = 2'd1,
        SINK_DONE   = 2'd2
    } sink_state_e;
endpackage

// File: rtl/pixel_sink_if.sv
// Drawer pixel stream plus VRAM write port; master is the drawer/VRAM side, slave is the sink.
interface pixel_sink_if #(
    parameter int ADDR_WIDTH = 15
) ();
    import pixel_sink_pkg::*;

    logic                     plot;
    logic [X_COORD_WIDTH-1:0] x;
    logic [Y_COORD_WIDTH-1:0] y;
    logic [COLOUR_WIDTH-1:0]  colour;
    logic                     finished;
    logic                     ready;
    logic                     vram_req;
    logic [ADDR_WIDTH-1:0]    vram_addr;
    logic [COLOUR_WIDTH-1:0]  vram_data;
    logic                     vram_grant;
    logic                     frame_done;

    modport master (
        output plot, x, y, colour, finished, vram_grant,
        input  ready, vram_req, vram_addr, vram_data, frame_done
    );

    modport slave (
        input  plot, x, y, colour, finished, vram_grant,
        output ready, vram_req, vram_addr, vram_data, frame_done
    );
endinterface

// File: rtl/pixel_fifo.sv
// Generic FIFO, synchronous active-high reset; pushed data visible at head one cycle later.
// Push on full and pop on empty are ignored; push and pop together keep the count.
module pixel_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/pixel_sink.sv
// Clips/linearises drawer pixels into a FIFO and writes them to VRAM under grant; accept-to-vram_req 1 cycle.
// ready drops when full or outside ACCEPT; PIXEL_SINK_STATS_EN adds written_count/clipped_count.
module pixel_sink
    import pixel_sink_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 15
) (
    input  logic        clock,
    input  logic        reset,
    pixel_sink_if.slave bus
`ifdef PIXEL_SINK_STATS_EN
    ,
    output logic [15:0] written_count,
    output logic [15:0] clipped_count
`endif
);
    localparam int ENTRY_W = ADDR_WIDTH + COLOUR_WIDTH;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    sink_state_e           state_q, state_d;
    logic                  ready, frame_done;
    logic                  accept, clipped, push, pop, drained;
    logic                  fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [ADDR_WIDTH-1:0] pix_addr;
    logic [ENTRY_W-1:0]    head;

    assign clipped  = (bus.x >= X_COORD_WIDTH'(SCREEN_WIDTH)) ||
                      (bus.y >= Y_COORD_WIDTH'(SCREEN_HEIGHT));
    assign pix_addr = ADDR_WIDTH'(bus.y) * ADDR_WIDTH'(SCREEN_WIDTH) + ADDR_WIDTH'(bus.x);
    assign accept   = bus.plot && ready;
    assign push     = accept && !clipped;
    assign pop      = !fifo_empty && bus.vram_grant;
    // Drain completes on the cycle whose pop empties the FIFO, so frame_done follows the last write directly.
    assign drained  = fifo_empty || (pop && (fifo_count == CNT_W'(1)));

    pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({pix_addr, bus.colour}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (head)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SINK_ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SINK_ACCEPT: if (bus.finished) state_d = SINK_DRAIN;
            SINK_DRAIN:  if (drained)      state_d = SINK_DONE;
            SINK_DONE:                     state_d = SINK_ACCEPT;
            default:                       state_d = SINK_ACCEPT;
        endcase
    end

    always_comb begin
        ready      = (state_q == SINK_ACCEPT) && !fifo_full;
        frame_done = (state_q == SINK_DONE);
    end

    assign bus.ready      = ready;
    assign bus.frame_done = frame_done;
    assign bus.vram_req   = !fifo_empty;
    assign bus.vram_addr  = head[ENTRY_W-1:COLOUR_WIDTH];
    assign bus.vram_data  = head[COLOUR_WIDTH-1:0];

`ifdef PIXEL_SINK_STATS_EN
    logic [15:0] written_q, written_d, clip_cnt_q, clip_cnt_d;

    // Counters hold through DONE so they can be sampled alongside frame_done.
    always_comb begin
        written_d  = written_q;
        clip_cnt_d = clip_cnt_q;
        if (state_q == SINK_DONE) begin
            written_d  = '0;
            clip_cnt_d = '0;
        end else begin
            if (pop && (written_q != 16'hFFFF)) begin
                written_d = written_q + 16'd1;
            end
            if (accept && clipped && (clip_cnt_q != 16'hFFFF)) begin
                clip_cnt_d = clip_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            written_q  <= '0;
            clip_cnt_q <= '0;
        end else begin
            written_q  <= written_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign written_count = written_q;
    assign clipped_count = clip_cnt_q;
`endif
endmodule

// File: tb/tb_pixel_sink.sv
// Self-checking bench for pixel_sink: directed scenarios plus a randomized run against a queue-based model.
module tb_pixel_sink;
    import pixel_sink_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 15;

    logic clock = 1'b0;
    logic reset = 1'b1;

    pixel_sink_if #(.ADDR_WIDTH(AW)) bus ();
`ifdef PIXEL_SINK_STATS_EN
    logic [15:0] written_count, clipped_count;
`endif

    pixel_sink #(
        .FIFO_DEPTH (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef PIXEL_SINK_STATS_EN
        ,
        .written_count (written_count),
        .clipped_count (clipped_count)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: pending pixels as queues, pass phase 0=accepting 1=draining 2=done.
    int m_addr_q[$];
    int m_col_q[$];
    int m_phase = 0;
    int m_wr    = 0;
    int m_cl    = 0;
    int errors  = 0;
    int checks  = 0;

    function automatic bit m_ready();
        return (m_phase == 0) && (m_addr_q.size() < DEPTH);
    endfunction

    task automatic tick();
        bit acc, pop, clip, fin;
        int ax, ay, ac;
        acc  = bus.plot && m_ready();
        pop  = bus.vram_grant && (m_addr_q.size() > 0);
        fin  = bus.finished;
        ax   = int'(bus.x);
        ay   = int'(bus.y);
        ac   = int'(bus.colour);
        clip = (ax >= SCREEN_WIDTH) || (ay >= SCREEN_HEIGHT);
        @(posedge clock);
        if (reset) begin
            m_addr_q.delete();
            m_col_q.delete();
            m_phase = 0;
            m_wr    = 0;
            m_cl    = 0;
        end else begin
            if (m_phase == 2) begin
                m_wr = 0;
                m_cl = 0;
            end
            if (pop) begin
                void'(m_addr_q.pop_front());
                void'(m_col_q.pop_front());
                if (m_wr < 65535) m_wr++;
            end
            if (acc) begin
                if (clip) begin
                    if (m_cl < 65535) m_cl++;
                end else begin
                    m_addr_q.push_back(ay * SCREEN_WIDTH + ax);
                    m_col_q.push_back(ac);
                end
            end
            case (m_phase)
                0:       if (fin) m_phase = 1;
                1:       if (m_addr_q.size() == 0) m_phase = 2;
                default: m_phase = 0;
            endcase
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.plot = 1'b1; bus.x = 8'd3; bus.y = 7'd0; bus.colour = 3'd7;
        @(negedge clock);
        tick();
        reset = 1'b0; bus.plot = 1'b0;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
        checks++; if (bus.vram_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.vram_req); end
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done); end
        checks++; if (bus.vram_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", bus.vram_addr); end
        checks++; if (bus.vram_data !== '0) begin errors++; $display("FAIL reset_data: got %0d want 0", bus.vram_data); end
        tick();
        checks++; if (bus.vram_req !== 1'b0) begin errors++; $display("FAIL reset_no_push: got %b want 0", bus.vram_req); end
    endtask

    task automatic test_single();
        bus.vram_grant = 1'b1; bus.plot = 1'b1; bus.x = 8'd5; bus.y = 7'd2; bus.colour = 3'b101;
        tick();
        bus.plot = 1'b0;
        checks++; if (bus.vram_req !== 1'b1) begin errors++; $display("FAIL single_req: got %b want 1", bus.vram_req); end
        checks++; if (bus.vram_addr !== AW'(2 * SCREEN_WIDTH + 5)) begin errors++; $display("FAIL single_addr: got %0d want %0d", bus.vram_addr, 2 * SCREEN_WIDTH + 5); end
        checks++; if (bus.vram_data !== 3'b101) begin errors++; $display("FAIL single_data: got %b want 101", bus.vram_data); end
        tick();
        checks++; if (bus.vram_req !== 1'b0) begin errors++; $display("FAIL single_req_after_pop: got %b want 0", bus.vram_req); end
    endtask

    task automatic test_backpressure();
        int px[5], py[5], pc[5];
        int k;
        bit acc;
        for (int i = 0; i < 5; i++) begin
            px[i] = $urandom_range(0, SCREEN_WIDTH - 1);
            py[i] = $urandom_range(0, SCREEN_HEIGHT - 1);
            pc[i] = $urandom_range(0, 7);
        end
        bus.vram_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.plot = 1'b1; bus.x = X_COORD_WIDTH'(px[i]); bus.y = Y_COORD_WIDTH'(py[i]); bus.colour = COLOUR_WIDTH'(pc[i]);
            checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL bp_ready_fill%0d: got %b want 1", i, bus.ready); end
            tick();
        end
        bus.x = X_COORD_WIDTH'(px[4]); bus.y = Y_COORD_WIDTH'(py[4]); bus.colour = COLOUR_WIDTH'(pc[4]);
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", bus.ready); end
            tick();
        end
        checks++; if (bus.vram_addr !== AW'(py[0] * SCREEN_WIDTH + px[0])) begin errors++; $display("FAIL bp_head_stable: got %0d want %0d", bus.vram_addr, py[0] * SCREEN_WIDTH + px[0]); end
        bus.vram_grant = 1'b1;
        k = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc == 1) begin
                checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b want 1", bus.ready); end
            end
            if (bus.vram_req === 1'b1 && k < 5) begin
                checks++;
                if (bus.vram_addr !== AW'(py[k] * SCREEN_WIDTH + px[k]) || bus.vram_data !== COLOUR_WIDTH'(pc[k])) begin
                    errors++; $display("FAIL bp_order%0d: got addr %0d data %0d want addr %0d data %0d", k, bus.vram_addr, bus.vram_data, py[k] * SCREEN_WIDTH + px[k], pc[k]);
                end
                k++;
            end
            acc = bus.plot && m_ready();
            tick();
            if (acc) bus.plot = 1'b0;
        end
        checks++; if (k != 5) begin errors++; $display("FAIL bp_write_count: got %0d want 5", k); end
    endtask

    task automatic test_clip();
        bus.vram_grant = 1'b0; bus.plot = 1'b1; bus.colour = 3'd2;
        bus.x = X_COORD_WIDTH'(SCREEN_WIDTH); bus.y = 7'd0;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL clip_ready_x: got %b want 1", bus.ready); end
        tick();
        bus.x = 8'd0; bus.y = Y_COORD_WIDTH'(SCREEN_HEIGHT);
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL clip_ready_y: got %b want 1", bus.ready); end
        tick();
        bus.plot = 1'b0;
        checks++; if (bus.vram_req !== 1'b0) begin errors++; $display("FAIL clip_req: got %b want 0", bus.vram_req); end
        tick();
        checks++; if (bus.vram_req !== 1'b0) begin errors++; $display("FAIL clip_req_later: got %b want 0", bus.vram_req); end
`ifdef PIXEL_SINK_STATS_EN
        checks++; if (clipped_count !== 16'd2) begin errors++; $display("FAIL clip_count: got %0d want 2", clipped_count); end
`endif
    endtask

    task automatic test_drain();
        int pops, fd_cnt, fd_cyc, last_pop;
        bus.vram_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.plot = 1'b1;
            bus.x = X_COORD_WIDTH'($urandom_range(0, SCREEN_WIDTH - 1));
            bus.y = Y_COORD_WIDTH'($urandom_range(0, SCREEN_HEIGHT - 1));
            bus.colour = COLOUR_WIDTH'($urandom_range(0, 7));
            tick();
        end
        bus.plot = 1'b0; bus.finished = 1'b1;
        tick();
        bus.finished = 1'b0;
        pops = 0; fd_cnt = 0; fd_cyc = -1; last_pop = -1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            bus.vram_grant = (cyc % 2 == 0);
            if (bus.frame_done === 1'b1) begin
                fd_cnt++; fd_cyc = cyc;
`ifdef PIXEL_SINK_STATS_EN
                checks++; if (written_count !== 16'(m_wr) || clipped_count !== 16'(m_cl)) begin errors++; $display("FAIL drain_stats_at_done: got %0d/%0d want %0d/%0d", written_count, clipped_count, m_wr, m_cl); end
`endif
            end
            if (fd_cnt == 0 || fd_cyc == cyc) begin
                checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL drain_ready_low cyc%0d: got %b want 0", cyc, bus.ready); end
            end else begin
                checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL drain_ready_after_done: got %b want 1", bus.ready); end
`ifdef PIXEL_SINK_STATS_EN
                checks++; if (written_count !== 16'd0 || clipped_count !== 16'd0) begin errors++; $display("FAIL drain_stats_cleared: got %0d/%0d want 0/0", written_count, clipped_count); end
`endif
                break;
            end
            if (bus.vram_req === 1'b1 && bus.vram_grant) begin
                pops++;
                if (pops == 3) last_pop = cyc;
            end
            tick();
        end
        bus.vram_grant = 1'b0;
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL drain_done_pulses: got %0d want 1", fd_cnt); end
        checks++; if (fd_cyc != last_pop + 1) begin errors++; $display("FAIL drain_done_timing: got cycle %0d want %0d", fd_cyc, last_pop + 1); end
    endtask

    task automatic test_reset_mid();
        bus.vram_grant = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.plot = 1'b1;
            bus.x = X_COORD_WIDTH'($urandom_range(0, SCREEN_WIDTH - 1));
            bus.y = Y_COORD_WIDTH'($urandom_range(0, SCREEN_HEIGHT - 1));
            bus.colour = COLOUR_WIDTH'($urandom_range(1, 7));
            tick();
        end
        bus.plot = 1'b0; bus.finished = 1'b1;
        tick();
        bus.finished = 1'b0;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL rmid_in_drain: got ready %b want 0", bus.ready); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.vram_req !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b want 0", bus.vram_req); end
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", bus.ready); end
        bus.vram_grant = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rmid_no_done%0d: got %b want 0", i, bus.frame_done); end
        end
    endtask

    task automatic test_random();
        bit acc;
        bus.plot = 1'b0; bus.finished = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            checks++; if (bus.ready !== m_ready()) begin errors++; $display("FAIL rnd_ready cyc%0d: got %b want %b", cyc, bus.ready, m_ready()); end
            checks++; if (bus.vram_req !== (m_addr_q.size() > 0)) begin errors++; $display("FAIL rnd_req cyc%0d: got %b want %b", cyc, bus.vram_req, m_addr_q.size() > 0); end
            checks++; if (bus.frame_done !== (m_phase == 2)) begin errors++; $display("FAIL rnd_done cyc%0d: got %b want %b", cyc, bus.frame_done, m_phase == 2); end
            if (m_addr_q.size() > 0) begin
                checks++;
                if (bus.vram_addr !== AW'(m_addr_q[0]) || bus.vram_data !== COLOUR_WIDTH'(m_col_q[0])) begin
                    errors++; $display("FAIL rnd_head cyc%0d: got %0d/%0d want %0d/%0d", cyc, bus.vram_addr, bus.vram_data, m_addr_q[0], m_col_q[0]);
                end
            end
`ifdef PIXEL_SINK_STATS_EN
            checks++; if (written_count !== 16'(m_wr) || clipped_count !== 16'(m_cl)) begin errors++; $display("FAIL rnd_stats cyc%0d: got %0d/%0d want %0d/%0d", cyc, written_count, clipped_count, m_wr, m_cl); end
`endif
            bus.vram_grant = ($urandom_range(0, 2) != 0);
            bus.finished   = ($urandom_range(0, 24) == 0);
            acc = bus.plot && m_ready();
            tick();
            if (!bus.plot || acc) begin
                bus.plot   = ($urandom_range(0, 3) != 0);
                bus.x      = X_COORD_WIDTH'($urandom_range(0, 200));
                bus.y      = Y_COORD_WIDTH'($urandom_range(0, 127));
                bus.colour = COLOUR_WIDTH'($urandom_range(0, 7));
            end
        end
        bus.plot = 1'b0; bus.finished = 1'b0;
    endtask

    initial begin
        bus.plot = 1'b0; bus.x = '0; bus.y = '0; bus.colour = '0;
        bus.finished = 1'b0; bus.vram_grant = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_clip();
        test_drain();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
